// File: rtl/gru_sequence_ctrl.sv
// Steps a gruCell through SEQ_LEN timesteps, feeding each captured h_t back as h_t_minus_1.
// Latency: per step 1 FETCH cycle + CELL_LATENCY+1 WAIT cycles; final state presented one cycle later.
// Backpressure: x_ready only in FETCH (waits indefinitely); h_out_valid holds h_out until h_out_ready.
module gru_sequence_ctrl #(
    parameter int WIDTH        = 16,
    parameter int NFRAC        = 12,
    parameter int x_SIZE       = 8,
    parameter int h_SIZE       = 8,
    parameter int SEQ_LEN      = 4,
    parameter int CELL_LATENCY = 3,
    localparam int SW          = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [WIDTH-1:0] x_in             [0:x_SIZE-1],
    output logic [WIDTH-1:0] cell_x_t         [0:x_SIZE-1],
    output logic [WIDTH-1:0] cell_h_t_minus_1 [0:h_SIZE-1],
    input  logic [WIDTH-1:0] cell_h_t         [0:h_SIZE-1],
    output logic [SW-1:0]    step_idx,
    output logic [WIDTH-1:0] h_out            [0:h_SIZE-1],
    output logic             h_out_valid,
    input  logic             h_out_ready
);

    localparam int LW = (CELL_LATENCY > 0) ? $clog2(CELL_LATENCY + 1) : 1;

    // Values are carried verbatim; the binary point only matters to the cell.
    if (NFRAC >= WIDTH || SEQ_LEN < 1 || CELL_LATENCY < 0) begin : g_param_check
        $error("gru_sequence_ctrl: invalid NFRAC/SEQ_LEN/CELL_LATENCY");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LW-1:0]     lat_cnt;
    logic [SW-1:0]     step_cnt;
    logic [WIDTH-1:0]  x_reg [0:x_SIZE-1];
    logic [WIDTH-1:0]  h_reg [0:h_SIZE-1];

    logic x_load;
    logic h_capture;
    logic h_clear;
    logic step_adv;
    logic lat_done;
    logic last_step;

    assign lat_done  = (lat_cnt == LW'(CELL_LATENCY));
    assign last_step = (step_cnt == SW'(SEQ_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        x_ready     = 1'b0;
        h_out_valid = 1'b0;
        x_load      = 1'b0;
        h_capture   = 1'b0;
        h_clear     = 1'b0;
        step_adv    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    h_clear   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    x_load    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_done) begin
                    h_capture = 1'b1;
                    if (last_step) begin
                        state_nxt = S_OUT;
                    end else begin
                        step_adv  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_OUT: begin
                h_out_valid = 1'b1;
                if (h_out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Cell inputs come straight from registers so they stay stable for the whole WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt  <= '0;
            step_cnt <= '0;
            for (int i = 0; i < x_SIZE; i++) x_reg[i] <= '0;
            for (int i = 0; i < h_SIZE; i++) h_reg[i] <= '0;
        end else begin
            if (h_clear) begin
                step_cnt <= '0;
            end else if (step_adv) begin
                step_cnt <= step_cnt + 1'b1;
            end

            if (x_load) begin
                lat_cnt <= '0;
            end else if (state == S_WAIT && !lat_done) begin
                lat_cnt <= lat_cnt + 1'b1;
            end

            if (x_load) begin
                for (int i = 0; i < x_SIZE; i++) x_reg[i] <= x_in[i];
            end

            if (h_clear) begin
                for (int i = 0; i < h_SIZE; i++) h_reg[i] <= '0;
            end else if (h_capture) begin
                for (int i = 0; i < h_SIZE; i++) h_reg[i] <= cell_h_t[i];
            end
        end
    end

    assign busy             = (state != S_IDLE);
    assign step_idx         = step_cnt;
    assign cell_x_t         = x_reg;
    assign cell_h_t_minus_1 = h_reg;
    assign h_out            = h_reg;

endmodule

// File: tb/tb_gru_sequence_ctrl.sv
// Randomized and directed bench for gru_sequence_ctrl; the cell is modelled as a pipelined
// element-wise add, and expectations come from running sums and the per-step cycle budget.
module tb_gru_sequence_ctrl;

    localparam int W   = 16;
    localparam int XS  = 8;
    localparam int HS  = 8;
    localparam int SEQ = 4;
    localparam int L   = 3;
    localparam int SW  = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic         x_valid = 1'b0;
    logic         x_ready;
    logic [W-1:0] x_in             [0:XS-1];
    logic [W-1:0] cell_x_t         [0:XS-1];
    logic [W-1:0] cell_h_t_minus_1 [0:HS-1];
    logic [W-1:0] cell_h_t         [0:HS-1];
    logic [SW-1:0] step_idx;
    logic [W-1:0] h_out            [0:HS-1];
    logic         h_out_valid;
    logic         h_out_ready = 1'b0;

    // Second instance: single step, combinational cell.
    logic         u_start = 1'b0;
    logic         u_busy;
    logic         u_x_valid = 1'b0;
    logic         u_x_ready;
    logic [W-1:0] u_x_in   [0:XS-1];
    logic [W-1:0] u_cell_x [0:XS-1];
    logic [W-1:0] u_cell_hm[0:HS-1];
    logic [W-1:0] u_cell_h [0:HS-1];
    logic [0:0]   u_step_idx;
    logic [W-1:0] u_h_out  [0:HS-1];
    logic         u_h_out_valid;
    logic         u_h_out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    gru_sequence_ctrl #(.WIDTH(W), .NFRAC(12), .x_SIZE(XS), .h_SIZE(HS),
                        .SEQ_LEN(SEQ), .CELL_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .x_valid(x_valid), .x_ready(x_ready), .x_in(x_in),
        .cell_x_t(cell_x_t), .cell_h_t_minus_1(cell_h_t_minus_1), .cell_h_t(cell_h_t),
        .step_idx(step_idx), .h_out(h_out), .h_out_valid(h_out_valid),
        .h_out_ready(h_out_ready)
    );

    gru_sequence_ctrl #(.WIDTH(W), .NFRAC(12), .x_SIZE(XS), .h_SIZE(HS),
                        .SEQ_LEN(1), .CELL_LATENCY(0)) dut1 (
        .clk(clk), .reset(reset), .start(u_start), .busy(u_busy),
        .x_valid(u_x_valid), .x_ready(u_x_ready), .x_in(u_x_in),
        .cell_x_t(u_cell_x), .cell_h_t_minus_1(u_cell_hm), .cell_h_t(u_cell_h),
        .step_idx(u_step_idx), .h_out(u_h_out), .h_out_valid(u_h_out_valid),
        .h_out_ready(u_h_out_ready)
    );

    always #5 clk = ~clk;

    // Cell model: h_t = h_t_minus_1 + x_t, delayed by L register stages.
    logic [W-1:0] pipe [0:L-1][0:HS-1];
    always @(posedge clk) begin
        for (int i = 0; i < HS; i++) pipe[0][i] <= cell_h_t_minus_1[i] + cell_x_t[i];
        for (int s = 1; s < L; s++)
            for (int i = 0; i < HS; i++) pipe[s][i] <= pipe[s-1][i];
    end
    always_comb begin
        for (int i = 0; i < HS; i++) cell_h_t[i] = pipe[L-1][i];
        for (int i = 0; i < HS; i++) u_cell_h[i] = u_cell_hm[i] + u_cell_x[i];
    end

    logic [W-1:0] seq_x  [0:SEQ-1][0:XS-1];
    logic [W-1:0] obs_cx [0:SEQ-1][0:XS-1];
    logic [W-1:0] obs_ch [0:SEQ-1][0:HS-1];
    logic [W-1:0] obs_h  [0:HS-1];
    int xr_q[$];
    int valid_cyc, wait_chg, out_chg, obs_step, post_valid, post_busy, post_busy2;

    function automatic logic [W-1:0] exp_sum(input int n, input int i);
        logic [W-1:0] s;
        s = '0;
        for (int j = 0; j < n; j++) s = s + seq_x[j][i];
        return s;
    endfunction

    task automatic fill_seq(input int a, input int b, input int c, input int d);
        for (int i = 0; i < XS; i++) begin
            seq_x[0][i] = W'(a); seq_x[1][i] = W'(b);
            seq_x[2][i] = W'(c); seq_x[3][i] = W'(d);
        end
    endtask

    // Drives one sequence and records what the DUT did; scenario tasks judge the records.
    task automatic run_seq(input int stall_step, input int stall_n, input int ready_dly,
                           input bit start_in_out);
        int c, k, st, hs;
        xr_q.delete();
        wait_chg = 0; out_chg = 0; valid_cyc = -1; obs_step = -1;
        post_valid = 1; post_busy = 1; post_busy2 = 1;
        k = 0; st = 0; hs = -100;
        h_out_ready = 1'b0; x_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; c = 1;
        while (c < 400) begin
            if (h_out_valid) begin valid_cyc = c; break; end
            if (x_ready) xr_q.push_back(c);
            if (k > 0 && c >= hs + 1 && c <= hs + L + 1) begin
                for (int i = 0; i < XS; i++) begin
                    if (c == hs + 1) obs_cx[k-1][i] = cell_x_t[i];
                    else if (cell_x_t[i] != obs_cx[k-1][i]) wait_chg++;
                end
                for (int i = 0; i < HS; i++) begin
                    if (c == hs + 1) obs_ch[k-1][i] = cell_h_t_minus_1[i];
                    else if (cell_h_t_minus_1[i] != obs_ch[k-1][i]) wait_chg++;
                end
            end
            x_valid = 1'b0;
            if (x_ready && k < SEQ) begin
                if (k == stall_step && st < stall_n) st++;
                else begin
                    x_valid = 1'b1;
                    for (int i = 0; i < XS; i++) x_in[i] = seq_x[k][i];
                    hs = c; k++;
                end
            end
            @(posedge clk); #1; c++;
        end
        x_valid = 1'b0;
        if (valid_cyc >= 0) begin
            for (int i = 0; i < HS; i++) obs_h[i] = h_out[i];
            obs_step = int'(step_idx);
            for (int n = 0; n < ready_dly; n++) begin
                start = start_in_out && (n == ready_dly / 2);
                @(posedge clk); #1;
                start = 1'b0;
                if (!h_out_valid || !busy) out_chg++;
                for (int i = 0; i < HS; i++) if (h_out[i] != obs_h[i]) out_chg++;
            end
            h_out_ready = 1'b1; start = start_in_out;
            @(posedge clk); #1;
            h_out_ready = 1'b0; start = 1'b0;
            post_valid = int'(h_out_valid); post_busy = int'(busy);
            @(posedge clk); #1;
            post_busy2 = int'(busy);
        end
    endtask

    task automatic test_reset;
        int any;
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            start = 1'($urandom); x_valid = 1'($urandom); h_out_ready = 1'($urandom);
            for (int i = 0; i < XS; i++) x_in[i] = W'($urandom);
            @(posedge clk); #1;
            any = int'(busy | x_ready | h_out_valid | (|step_idx));
            for (int i = 0; i < HS; i++)
                any = any | int'(|h_out[i]) | int'(|cell_h_t_minus_1[i]) | int'(|cell_x_t[i]);
            checks++;
            if (any !== 0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: outputs nonzero busy=%b xr=%b hv=%b step=%0d",
                         n, busy, x_ready, h_out_valid, step_idx);
            end
        end
        start = 1'b0; x_valid = 1'b0; h_out_ready = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; x_valid = 1'b1;
        for (int i = 0; i < XS; i++) x_in[i] = 16'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1 || cell_x_t[0] !== 16'd5 || cell_h_t_minus_1[0] !== 16'd5) begin
            errors++;
            $display("FAIL reset_pre busy=%b cx=%0d ch=%0d required 1 5 5",
                     busy, cell_x_t[0], cell_h_t_minus_1[0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || x_ready !== 1'b0 || h_out_valid !== 1'b0 || step_idx !== '0 ||
            cell_x_t[0] !== '0 || cell_h_t_minus_1[0] !== '0 || h_out[0] !== '0) begin
            errors++;
            $display("FAIL reset_async busy=%b cx=%0d ch=%0d hout=%0d required all 0",
                     busy, cell_x_t[0], cell_h_t_minus_1[0], h_out[0]);
        end
        x_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int bad;
        int exp_xr[4] = '{1, 6, 11, 16};
        fill_seq(5, 6, 7, 8);
        run_seq(-1, 0, 0, 0);
        checks++;
        if (valid_cyc !== 21) begin
            errors++; $display("FAIL basic_valid_cycle got %0d required 21", valid_cyc);
        end
        bad = -1;
        for (int i = 0; i < HS; i++) if (obs_h[i] !== 16'd26) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL basic_h_out[%0d] got %0d required 26", bad, obs_h[bad]);
        end
        checks++;
        if (obs_step !== 3) begin
            errors++; $display("FAIL basic_step_idx got %0d required 3", obs_step);
        end
        bad = (xr_q.size() != 4) ? 1 : 0;
        for (int j = 0; j < 4 && bad == 0; j++) if (xr_q[j] != exp_xr[j]) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_x_ready_cycles got %p required 1 6 11 16", xr_q);
        end
        checks++;
        if (post_valid !== 0 || post_busy !== 0) begin
            errors++;
            $display("FAIL basic_after_handshake valid=%0d busy=%0d required 0 0",
                     post_valid, post_busy);
        end
    endtask

    task automatic test_stall;
        int bad, fs, nx;
        fill_seq(5, 6, 7, 8);
        run_seq(2, 5, 0, 0);
        checks++;
        if (valid_cyc !== 26) begin
            errors++; $display("FAIL stall_valid_cycle got %0d required 26", valid_cyc);
        end
        bad = -1;
        for (int i = 0; i < HS; i++) if (obs_h[i] !== 16'd26) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL stall_h_out[%0d] got %0d required 26", bad, obs_h[bad]);
        end
        checks++;
        if (wait_chg !== 0) begin
            errors++; $display("FAIL stall_wait_stable changes %0d required 0", wait_chg);
        end
        bad = 0;
        for (int k = 0; k < SEQ; k++)
            for (int i = 0; i < XS; i++)
                if (obs_cx[k][i] !== seq_x[k][i] || obs_ch[k][i] !== exp_sum(k, i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL stall_cell_inputs wrong elements %0d required 0", bad);
        end
        fs = 1; nx = 0; bad = 0;
        for (int k = 0; k < SEQ; k++) begin
            for (int s = 0; s <= ((k == 2) ? 5 : 0); s++) begin
                if (nx >= xr_q.size() || xr_q[nx] != fs + s) bad = 1;
                nx++;
            end
            fs = fs + ((k == 2) ? 5 : 0) + L + 2;
        end
        checks++;
        if (bad != 0 || nx != xr_q.size()) begin
            errors++; $display("FAIL stall_x_ready_cycles got %p", xr_q);
        end
    endtask

    task automatic test_out_hold;
        fill_seq(5, 6, 7, 8);
        run_seq(-1, 0, 10, 1);
        checks++;
        if (valid_cyc !== 21 || obs_h[3] !== 16'd26) begin
            errors++;
            $display("FAIL hold_result cycle %0d h %0d required 21 26", valid_cyc, obs_h[3]);
        end
        checks++;
        if (out_chg !== 0) begin
            errors++; $display("FAIL hold_stable changes %0d required 0", out_chg);
        end
        checks++;
        if (post_valid !== 0 || post_busy !== 0 || post_busy2 !== 0) begin
            errors++;
            $display("FAIL hold_release valid=%0d busy=%0d busy_next=%0d required 0 0 0",
                     post_valid, post_busy, post_busy2);
        end
    endtask

    task automatic test_abort;
        int hv, bad;
        hv = 0;
        start = 1'b1; x_valid = 1'b1;
        for (int i = 0; i < XS; i++) x_in[i] = 16'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (12) begin
            if (h_out_valid) hv++;
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || step_idx !== 2'd2 || x_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre busy=%b step=%0d xr=%b required 1 2 0",
                     busy, step_idx, x_ready);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || h_out_valid !== 1'b0 || h_out[0] !== '0 || hv !== 0) begin
            errors++;
            $display("FAIL abort_clear busy=%b hv=%b h=%0d early_valid=%0d required 0 0 0 0",
                     busy, h_out_valid, h_out[0], hv);
        end
        x_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        fill_seq(1, 1, 1, 1);
        run_seq(-1, 0, 0, 0);
        bad = -1;
        for (int i = 0; i < HS; i++) if (obs_h[i] !== 16'd4) bad = i;
        checks++;
        if (bad >= 0 || valid_cyc !== 21) begin
            errors++;
            $display("FAIL abort_rerun h[%0d]=%0d cycle %0d required 4 at 21",
                     (bad < 0) ? 0 : bad, obs_h[(bad < 0) ? 0 : bad], valid_cyc);
        end
    endtask

    task automatic test_back_to_back;
        int c, vc;
        for (int r = 0; r < 2; r++) begin
            fill_seq(5, 6, 7, 8);
            run_seq(-1, 0, 0, 0);
            checks++;
            if (obs_h[0] !== 16'd26 || obs_h[HS-1] !== 16'd26 || valid_cyc !== 21) begin
                errors++;
                $display("FAIL b2b_run%0d h=%0d/%0d cycle %0d required 26 at 21",
                         r, obs_h[0], obs_h[HS-1], valid_cyc);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < XS; i++) u_x_in[i] = 16'd9;
            u_start = 1'b1; u_x_valid = 1'b1; u_h_out_ready = 1'b1;
            @(posedge clk); #1; u_start = 1'b0; c = 1; vc = -1;
            while (c < 20) begin
                if (u_h_out_valid) begin
                    vc = c;
                    for (int i = 0; i < HS; i++) obs_h[i] = u_h_out[i];
                    break;
                end
                @(posedge clk); #1; c++;
            end
            u_x_valid = 1'b0;
            checks++;
            if (vc !== 3 || obs_h[0] !== 16'd9 || obs_h[HS-1] !== 16'd9) begin
                errors++;
                $display("FAIL single_step_run%0d cycle %0d h=%0d required 3 and 9",
                         r, vc, obs_h[0]);
            end
            @(posedge clk); #1; u_h_out_ready = 1'b0;
            checks++;
            if (u_busy !== 1'b0 || u_h_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_step_idle busy=%b hv=%b required 0 0", u_busy, u_h_out_valid);
            end
        end
    endtask

    task automatic test_random;
        int ss, sn, bad;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < SEQ; k++)
                for (int i = 0; i < XS; i++) seq_x[k][i] = W'($urandom);
            ss = $urandom_range(0, SEQ - 1);
            sn = $urandom_range(0, 6);
            run_seq(ss, sn, $urandom_range(0, 4), 1'($urandom));
            bad = -1;
            for (int i = 0; i < HS; i++) if (obs_h[i] !== exp_sum(SEQ, i)) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL rand%0d_h_out[%0d] got %0d required %0d",
                         r, bad, obs_h[bad], exp_sum(SEQ, bad));
            end
            checks++;
            if (valid_cyc !== 1 + SEQ * (L + 2) + sn || wait_chg !== 0 || out_chg !== 0) begin
                errors++;
                $display("FAIL rand%0d_timing cycle %0d required %0d wait_chg %0d out_chg %0d",
                         r, valid_cyc, 1 + SEQ * (L + 2) + sn, wait_chg, out_chg);
            end
            checks++;
            if (post_busy !== 0 || post_busy2 !== 0) begin
                errors++;
                $display("FAIL rand%0d_idle busy=%0d/%0d required 0", r, post_busy, post_busy2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < XS; i++) begin x_in[i] = '0; u_x_in[i] = '0; end
        test_reset();
        test_basic();
        test_stall();
        test_out_hold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
